pipeline_controller: RTL and testbench

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/pipeline_controller.sv | 140 ++++++++++++++
 tb/tb_pipeline_controller.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_controller.sv
// Pipeline hazard/stall controller: load-use stalls, branch flushes, memory-wait freeze
// with timeout-to-error, plus saturating stall and flush performance counters.
module pipeline_controller #(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic [4:0]           ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_branch_taken,
    input  logic [31:0]          ex_branch_target,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    output logic                 pc_load,
    output logic                 if_id_load,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 mux3_selector,
    output logic [31:0]          pc_branch_out,
    output logic                 pipe_freeze,
    output logic                 mem_timeout,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_count
);

    localparam int unsigned WAIT_W    = 8;
    localparam logic [WAIT_W-1:0] TIMEOUT_W = WAIT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        ERROR    = 2'd3
    } state_t;

    state_t              state, next_state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_inc;
    logic                wait_clr;
    logic                wait_en;
    logic                lu;
    logic                mem_stall;

    assign lu = ex_mem_read & (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    assign mem_stall     = mem_req & ~mem_ready;
    assign wait_inc      = wait_cnt + WAIT_W'(1);
    assign pc_branch_out = ex_branch_target;

    // Next-state and control outputs; while reset is held the RUN defaults apply.
    always_comb begin
        next_state    = state;
        pc_load       = 1'b1;
        if_id_load    = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mux3_selector = 1'b0;
        pipe_freeze   = 1'b0;
        wait_clr      = 1'b0;
        wait_en       = 1'b0;
        if (reset) begin
            case (state)
                RUN, LU_STALL: begin
                    next_state = RUN;
                    if (mem_stall) begin
                        pc_load     = 1'b0;
                        if_id_load  = 1'b0;
                        pipe_freeze = 1'b1;
                        wait_clr    = 1'b1;
                        next_state  = MEM_WAIT;
                    end else if (ex_branch_taken) begin
                        mux3_selector = 1'b1;
                        if_id_flush   = 1'b1;
                        id_ex_flush   = 1'b1;
                    end else if (state == RUN && lu) begin
                        pc_load     = 1'b0;
                        if_id_load  = 1'b0;
                        id_ex_flush = 1'b1;
                        next_state  = LU_STALL;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        next_state = RUN;
                    end else begin
                        pc_load     = 1'b0;
                        if_id_load  = 1'b0;
                        pipe_freeze = 1'b1;
                        wait_en     = 1'b1;
                        if (wait_inc >= TIMEOUT_W) begin
                            next_state = ERROR;
                        end
                    end
                end
                ERROR: begin
                    pc_load     = 1'b0;
                    if_id_load  = 1'b0;
                    pipe_freeze = 1'b1;
                end
                default: next_state = RUN;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Wait counter, sticky timeout flag and saturating performance counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (wait_clr) begin
                wait_cnt <= '0;
            end else if (wait_en) begin
                wait_cnt <= wait_inc;
            end
            if (next_state == ERROR) begin
                mem_timeout <= 1'b1;
            end
            if (!pc_load && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_WIDTH'(1);
            end
            if ((if_id_flush || id_ex_flush) && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: a default instance plus a TIMEOUT=4,
// CNT_WIDTH=2 instance sharing the same stimulus for timeout and saturation.
module tb_pipeline_controller;

    logic        clock;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic [31:0] ex_branch_target;

    logic        d_pc_load, d_if_id_load, d_if_id_flush, d_id_ex_flush, d_mux3, d_freeze, d_timeout;
    logic [31:0] d_pc_branch;
    logic [15:0] d_stall, d_flush;

    logic        t_pc_load, t_if_id_load, t_if_id_flush, t_id_ex_flush, t_mux3, t_freeze, t_timeout;
    logic [31:0] t_pc_branch;
    logic [1:0]  t_stall, t_flush;

    int tests = 0;
    int fails = 0;

    pipeline_controller dut (
        .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .ex_branch_target(ex_branch_target), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_load(d_pc_load), .if_id_load(d_if_id_load), .if_id_flush(d_if_id_flush),
        .id_ex_flush(d_id_ex_flush), .mux3_selector(d_mux3), .pc_branch_out(d_pc_branch),
        .pipe_freeze(d_freeze), .mem_timeout(d_timeout), .stall_cycles(d_stall),
        .flush_count(d_flush)
    );

    pipeline_controller #(.TIMEOUT(4), .CNT_WIDTH(2)) dut_t (
        .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .ex_branch_target(ex_branch_target), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_load(t_pc_load), .if_id_load(t_if_id_load), .if_id_flush(t_if_id_flush),
        .id_ex_flush(t_id_ex_flush), .mux3_selector(t_mux3), .pc_branch_out(t_pc_branch),
        .pipe_freeze(t_freeze), .mem_timeout(t_timeout), .stall_cycles(t_stall),
        .flush_count(t_flush)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ex_branch_target = 32'h0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        clock = 1'b0;
        reset = 1'b0;
        clear_inputs();
        mem_req = 1'b1;
        #1;
        // Reset held: RUN defaults regardless of a pending memory wait
        chk("rst_pc_load", d_pc_load, 1);
        chk("rst_freeze", d_freeze, 0);
        chk("rst_stall", d_stall, 0);
        chk("rst_flush", d_flush, 0);
        chk("rst_timeout", d_timeout, 0);
        tick(2);
        clear_inputs();
        reset = 1'b1;
        #1;

        // No hazard when ex_rd is x0
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
        #1;
        chk("x0_pc_load", d_pc_load, 1);
        chk("x0_id_ex_flush", d_id_ex_flush, 0);
        tick(1);

        // Load-use on rs2: one stall cycle, then LU_STALL with defaults
        ex_rd = 5'd5; id_rs1 = 5'd3; id_rs2 = 5'd5;
        #1;
        chk("lu_pc_load", d_pc_load, 0);
        chk("lu_if_id_load", d_if_id_load, 0);
        chk("lu_id_ex_flush", d_id_ex_flush, 1);
        chk("lu_if_id_flush", d_if_id_flush, 0);
        tick(1);
        chk("lus_pc_load", d_pc_load, 1);
        chk("lus_id_ex_flush", d_id_ex_flush, 0);
        chk("lus_stall", d_stall, 1);
        chk("lus_flush", d_flush, 1);
        clear_inputs();
        tick(1);

        // Branch beats load-use
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5;
        ex_branch_taken = 1'b1; ex_branch_target = 32'h40;
        #1;
        chk("br_mux3", d_mux3, 1);
        chk("br_target", d_pc_branch, 32'h40);
        chk("br_if_id_flush", d_if_id_flush, 1);
        chk("br_id_ex_flush", d_id_ex_flush, 1);
        chk("br_pc_load", d_pc_load, 1);
        tick(1);
        // Still in RUN: load-use now stalls
        ex_branch_taken = 1'b0;
        #1;
        chk("br_next_run", d_pc_load, 0);
        chk("br_flush_cnt", d_flush, 2);
        tick(1);
        // LU_STALL handles a taken branch like RUN
        ex_branch_taken = 1'b1;
        #1;
        chk("lus_br_mux3", d_mux3, 1);
        chk("lus_br_flush", d_if_id_flush, 1);
        tick(1);
        chk("flush_cnt4", d_flush, 4);
        chk("sat_flush_w2", t_flush, 3);
        clear_inputs();

        // Memory wait: ready low 3 cycles, branch ignored in MEM_WAIT
        mem_req = 1'b1;
        #1;
        chk("mw0_freeze", d_freeze, 1);
        chk("mw0_pc_load", d_pc_load, 0);
        tick(1);
        ex_branch_taken = 1'b1; ex_branch_target = 32'h80;
        #1;
        chk("mw1_freeze", d_freeze, 1);
        chk("mw1_mux3", d_mux3, 0);
        chk("mw1_if_id_flush", d_if_id_flush, 0);
        chk("mw1_target", d_pc_branch, 32'h80);
        tick(1);
        ex_branch_taken = 1'b0;
        #1;
        chk("mw2_freeze", d_freeze, 1);
        tick(1);
        mem_ready = 1'b1;
        #1;
        chk("mw_rdy_freeze", d_freeze, 0);
        chk("mw_rdy_pc_load", d_pc_load, 1);
        tick(1);
        chk("mw_stall_cnt", d_stall, 5);
        chk("sat_stall_w2", t_stall, 3);
        chk("mw_no_timeout", t_timeout, 0);
        // mem_ready without mem_req is ignored in RUN
        mem_req = 1'b0;
        #1;
        chk("rdy_only_pc_load", d_pc_load, 1);
        chk("rdy_only_freeze", d_freeze, 0);
        tick(1);

        // Timeout: TIMEOUT=4 instance reaches ERROR after four MEM_WAIT cycles
        mem_req = 1'b1; mem_ready = 1'b0;
        tick(4);
        chk("to_not_yet", t_timeout, 0);
        chk("to_wait_freeze", t_freeze, 1);
        tick(1);
        chk("to_set", t_timeout, 1);
        mem_req = 1'b0; mem_ready = 1'b1;
        #1;
        chk("err_pc_load", t_pc_load, 0);
        chk("err_freeze", t_freeze, 1);
        chk("dflt_exit_freeze", d_freeze, 0);
        tick(1);
        chk("err_sticky", t_timeout, 1);
        chk("dflt_no_timeout", d_timeout, 0);
        chk("dflt_stall10", d_stall, 10);

        // Reset inside ERROR returns to RUN and clears state
        reset = 1'b0;
        #1;
        chk("rst_err_timeout", t_timeout, 0);
        chk("rst_err_pc_load", t_pc_load, 1);
        chk("rst_err_stall", t_stall, 0);
        tick(1);
        reset = 1'b1;
        clear_inputs();
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7;
        #1;
        chk("post_rst_lu", t_id_ex_flush, 1);
        chk("post_rst_freeze", t_freeze, 0);
        tick(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
